// File: rtl/gpo_pad_ctrl_if.sv
// gpo_pad_ctrl configuration bus
// valid/ready write channel plus status back to core
interface gpo_pad_ctrl_if;
  logic       cfg_valid_i;
  logic       cfg_ready_o;
  logic [3:0] cfg_ds_i;
  logic       cfg_sr_i;
  logic       cfg_co_i;
  logic [1:0] cfg_mode_i;
  logic       busy_o;
  logic       cfg_err_o;

  modport master (
    output cfg_valid_i,
    output cfg_ds_i,
    output cfg_sr_i,
    output cfg_co_i,
    output cfg_mode_i,
    input  cfg_ready_o,
    input  busy_o,
    input  cfg_err_o
  );

  modport slave (
    input  cfg_valid_i,
    input  cfg_ds_i,
    input  cfg_sr_i,
    input  cfg_co_i,
    input  cfg_mode_i,
    output cfg_ready_o,
    output busy_o,
    output cfg_err_o
  );
endinterface

// File: rtl/gpo_pad_ctrl.sv
// gpo_pad_ctrl: core-side driver for the EG1D80V GPO pad
// glitch-free config updates via drain/apply/settle
module gpo_pad_ctrl #(
  parameter int         SETTLE_CYCLES = 4,
  parameter logic [3:0] DS_RST        = 4'b0000
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          data_i,
  input  logic          oe_i,
  input  logic          vbias_ok_i,
  gpo_pad_ctrl_if.slave cfg,
  output logic          DO_O,
  output logic          OE_O,
  output logic [3:0]    DS_O,
  output logic          SR_O,
  output logic          CO_O,
  output logic          ODP_O,
  output logic          ODN_O,
  output logic          vbias_lost_o
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] C_LOAD = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_APPLY,
    S_SETTLE
  } state_t;

  typedef struct packed {
    logic [3:0] ds;
    logic       sr;
    logic       co;
    logic [1:0] mode;
  } cfg_t;

  state_t        r_state;
  state_t        w_nxt;
  logic [CW-1:0] r_cnt;
  cfg_t          r_act;
  cfg_t          r_sh;
  cfg_t          w_req;
  logic          r_vb_meta;
  logic          r_vb_s;
  logic          r_do;
  logic          r_oe;
  logic          r_err;
  logic          r_lost;
  logic          w_ready;
  logic          w_busy;
  logic          w_gate;
  logic          w_acc;
  logic          w_rej;
  logic          w_go;
  logic          w_cnt_one;
  logic          w_act_hi;
  logic          w_oe_nxt;

  assign w_req = {cfg.cfg_ds_i, cfg.cfg_sr_i,
                  cfg.cfg_co_i, cfg.cfg_mode_i};

  // A high-drive request without VBIAS is refused;
  // an identical request needs no pad quiesce.
  assign w_acc     = cfg.cfg_valid_i & w_ready;
  assign w_rej     = w_acc & (w_req.ds[1:0] != 2'b00)
                   & ~r_vb_s;
  assign w_go      = w_acc & ~w_rej & (w_req != r_act);
  assign w_cnt_one = (r_cnt == C_ONE);
  assign w_act_hi  = (r_act.ds[1:0] != 2'b00);

  // Gate covers the accept cycle too, so OE drops
  // in the very next cycle after a config accept.
  assign w_oe_nxt = oe_i & ~w_gate
                  & (r_act.mode != 2'b11)
                  & ~(w_act_hi & ~r_vb_s);

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (w_go) w_nxt = S_DRAIN;
      S_DRAIN:  if (w_cnt_one) w_nxt = S_APPLY;
      S_APPLY:  w_nxt = S_SETTLE;
      S_SETTLE: if (w_cnt_one) w_nxt = S_IDLE;
      default:  w_nxt = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_ready = (r_state == S_IDLE);
    w_busy  = (r_state != S_IDLE);
    w_gate  = (r_state != S_IDLE) | (w_nxt != S_IDLE);
  end

  // Quiesce/settle counter, saturates at zero
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else begin
      unique case (r_state)
        S_IDLE:  if (w_go) r_cnt <= C_LOAD;
        S_APPLY: r_cnt <= C_LOAD;
        default: if (r_cnt != '0) r_cnt <= r_cnt - C_ONE;
      endcase
    end
  end

  // Shadow capture on accept, active update in APPLY
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sh  <= '0;
      r_act <= {DS_RST, 1'b0, 1'b0, 2'b00};
    end else begin
      if (w_go) r_sh <= w_req;
      if (r_state == S_APPLY) r_act <= r_sh;
    end
  end

  // Two-flop VBIAS-ready synchronizer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_vb_meta <= 1'b0;
      r_vb_s    <= 1'b0;
    end else begin
      r_vb_meta <= vbias_ok_i;
      r_vb_s    <= r_vb_meta;
    end
  end

  // Registered pad data/enable and status flags
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_do   <= 1'b0;
      r_oe   <= 1'b0;
      r_err  <= 1'b0;
      r_lost <= 1'b0;
    end else begin
      r_do   <= data_i;
      r_oe   <= w_oe_nxt;
      r_err  <= w_rej;
      r_lost <= w_act_hi & ~r_vb_s;
    end
  end

  assign DO_O         = r_do;
  assign OE_O         = r_oe;
  assign DS_O         = r_act.ds;
  assign SR_O         = r_act.sr;
  assign CO_O         = r_act.co;
  assign ODP_O        = (r_act.mode == 2'b01);
  assign ODN_O        = (r_act.mode == 2'b10);
  assign vbias_lost_o = r_lost;

  assign cfg.cfg_ready_o = w_ready;
  assign cfg.busy_o      = w_busy;
  assign cfg.cfg_err_o   = r_err;

endmodule
